rsfq_merge_sync_model: RTL and testbench



---
 rtl/rsfq_timing_pkg.sv | 21 ++
 rtl/rsfq_merge_sync_model_if.sv | 21 ++
 rtl/pulse_delay_line.sv | 24 ++
 rtl/rsfq_merge_sync_model.sv | 98 +++++++++
 tb/tb_rsfq_merge_sync_model.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/rsfq_timing_pkg.sv
// Shared timing constants and cell state encoding for the synchronous RSFQ cell models.
// One clock cycle is one simulation quantum of QUANTUM_FS femtoseconds.
package rsfq_timing_pkg;

   localparam int unsigned QUANTUM_FS      = 500;
   localparam int unsigned MERGE_DELAY_DEF = 11;
   localparam int unsigned MERGE_CT_DEF    = 7;
   localparam int unsigned STARTUP_DEF     = 8;

   typedef enum logic [1:0] {
      STARTUP,
      IDLE,
      BLOCKED
   } cell_state_t;

   // Width of a down-counter that must hold values 0..n.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rsfq_merge_sync_model_if.sv
// Toggle-encoded pulse inputs and merged output / violation status of the merger cell.
interface rsfq_merge_sync_model_if #(
   parameter int unsigned ERR_W = 8
);
   logic             a;
   logic             b;
   logic             q;
   logic             err_pulse;
   logic             err;
   logic [ERR_W-1:0] err_count;

   modport master (
      output a, b,
      input  q, err_pulse, err, err_count
   );

   modport slave (
      input  a, b,
      output q, err_pulse, err, err_count
   );
endinterface

// File: rtl/pulse_delay_line.sv
// Fixed-depth pulse shift register shared by the clocked RSFQ cell models.
module pulse_delay_line #(
   parameter int unsigned DELAY_CYCLES = 11
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic out
);
   logic [DELAY_CYCLES-1:0] sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else begin
         sr[0] <= in;
         for (int unsigned i = 1; i < DELAY_CYCLES; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign out = sr[DELAY_CYCLES-1];
endmodule

// File: rtl/rsfq_merge_sync_model.sv
// Two-input RSFQ confluence cell: merges toggle-encoded pulses onto q after a fixed
// delay and flags pulses that fall inside the critical-timing window of the last accept.
module rsfq_merge_sync_model
   import rsfq_timing_pkg::*;
#(
   parameter int unsigned DELAY_CYCLES   = MERGE_DELAY_DEF,
   parameter int unsigned CT_CYCLES      = MERGE_CT_DEF,
   parameter int unsigned STARTUP_CYCLES = STARTUP_DEF,
   parameter int unsigned ERR_W          = 8
) (
   input logic                    clk,
   input logic                    rst,
   rsfq_merge_sync_model_if.slave bus
);
   localparam int unsigned WIN_W = cnt_w(CT_CYCLES);
   localparam int unsigned SU_W  = cnt_w(STARTUP_CYCLES);
   localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(CT_CYCLES);
   localparam logic [SU_W-1:0]  SU_LOAD  = SU_W'(STARTUP_CYCLES);

   cell_state_t      state, state_nxt;
   logic             a_d, b_d;
   logic [SU_W-1:0]  su_cnt, su_nxt;
   logic [WIN_W-1:0] win_cnt, win_nxt;
   logic             pa, pb, live, blocked, accept, viol;
   logic             viol_q, tail;
   logic             q_r, err_pulse_r, err_r;
   logic [ERR_W-1:0] err_count_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= STARTUP;
      else     state <= state_nxt;
   end

   // BLOCKED mirrors a nonzero window counter one-for-one.
   always_comb begin
      su_nxt  = (su_cnt != '0) ? su_cnt - 1'b1 : '0;
      win_nxt = '0;
      if (accept)              win_nxt = WIN_LOAD;
      else if (win_cnt != '0)  win_nxt = win_cnt - 1'b1;

      state_nxt = state;
      case (state)
         STARTUP: begin
            if (win_nxt != '0)     state_nxt = BLOCKED;
            else if (su_nxt == '0) state_nxt = IDLE;
         end
         IDLE:    if (win_nxt != '0) state_nxt = BLOCKED;
         BLOCKED: if (win_nxt == '0) state_nxt = IDLE;
         default: state_nxt = STARTUP;
      endcase
   end

   // A simultaneous A/B pair is a single violation event even when one pulse is accepted.
   always_comb begin
      pa      = bus.a ^ a_d;
      pb      = bus.b ^ b_d;
      live    = (state != STARTUP) || (su_cnt == '0);
      blocked = (state == BLOCKED);
      accept  = live && !blocked && (pa || pb);
      viol    = live && ((blocked && (pa || pb)) || (pa && pb));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_d         <= 1'b0;
         b_d         <= 1'b0;
         su_cnt      <= SU_LOAD;
         win_cnt     <= '0;
         viol_q      <= 1'b0;
         q_r         <= 1'b0;
         err_pulse_r <= 1'b0;
         err_r       <= 1'b0;
         err_count_r <= '0;
      end else begin
         a_d         <= bus.a;
         b_d         <= bus.b;
         su_cnt      <= su_nxt;
         win_cnt     <= win_nxt;
         viol_q      <= viol;
         q_r         <= q_r ^ tail;
         err_pulse_r <= viol_q;
         err_r       <= err_r | viol_q;
         if (viol_q && (err_count_r != '1)) err_count_r <= err_count_r + 1'b1;
      end
   end

   pulse_delay_line #(.DELAY_CYCLES(DELAY_CYCLES)) u_dly (
      .clk (clk),
      .rst (rst),
      .in  (accept),
      .out (tail)
   );

   assign bus.q         = q_r;
   assign bus.err_pulse = err_pulse_r;
   assign bus.err       = err_r;
   assign bus.err_count = err_count_r;
endmodule

// File: tb/tb_rsfq_merge_sync_model.sv
// Directed bench for the merger cell: table of single-scenario checkpoints plus
// hand-written multi-cycle sequences; a second instance with a 2-bit counter checks saturation.
module tb_rsfq_merge_sync_model;
   import rsfq_timing_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a   = 1'b0;
   logic b   = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   rsfq_merge_sync_model_if #(.ERR_W(8)) bus  ();
   rsfq_merge_sync_model_if #(.ERR_W(2)) bus2 ();

   assign bus.a  = a;
   assign bus.b  = b;
   assign bus2.a = a;
   assign bus2.b = b;

   rsfq_merge_sync_model #(
      .DELAY_CYCLES(11), .CT_CYCLES(7), .STARTUP_CYCLES(8), .ERR_W(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   rsfq_merge_sync_model #(
      .DELAY_CYCLES(11), .CT_CYCLES(7), .STARTUP_CYCLES(8), .ERR_W(2)
   ) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   typedef struct {
      int   ta;
      int   tb;
      int   chk;
      logic q;
      logic ep;
      logic er;
      int   cnt;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      a   = 1'b0;
      b   = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
   endtask

   // Toggle the requested inputs so the edge is seen at the next rising clock edge.
   task automatic step(input bit ta, input bit tb);
      if (ta) a = ~a;
      if (tb) b = ~b;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step(1'b0, 1'b0);
   endtask

   task automatic check_all(input string tag, input logic q, input logic ep,
                            input logic er, input int cnt);
      check({tag, ".q"},         32'(bus.q),         32'(q));
      check({tag, ".err_pulse"}, 32'(bus.err_pulse), 32'(ep));
      check({tag, ".err"},       32'(bus.err),       32'(er));
      check({tag, ".err_count"}, 32'(bus.err_count), 32'(cnt));
   endtask

   initial begin
      //           ta  tb  chk  q  ep er cnt
      vecs[0]  = '{20,  0, 30, 1'b0, 1'b0, 1'b0, 0};
      vecs[1]  = '{20,  0, 31, 1'b1, 1'b0, 1'b0, 0};
      vecs[2]  = '{20, 28, 31, 1'b1, 1'b0, 1'b0, 0};
      vecs[3]  = '{20, 28, 38, 1'b1, 1'b0, 1'b0, 0};
      vecs[4]  = '{20, 28, 39, 1'b0, 1'b0, 1'b0, 0};
      vecs[5]  = '{20, 27, 27, 1'b0, 1'b0, 1'b0, 0};
      vecs[6]  = '{20, 27, 28, 1'b0, 1'b1, 1'b1, 1};
      vecs[7]  = '{20, 27, 29, 1'b0, 1'b0, 1'b1, 1};
      vecs[8]  = '{20, 27, 31, 1'b1, 1'b0, 1'b1, 1};
      vecs[9]  = '{20, 27, 45, 1'b1, 1'b0, 1'b1, 1};
      vecs[10] = '{40, 40, 41, 1'b0, 1'b1, 1'b1, 1};
      vecs[11] = '{40, 40, 51, 1'b1, 1'b0, 1'b1, 1};
      vecs[12] = '{40, 40, 60, 1'b1, 1'b0, 1'b1, 1};
      vecs[13] = '{ 3,  5, 25, 1'b0, 1'b0, 1'b0, 0};
      vecs[14] = '{ 9,  0, 19, 1'b0, 1'b0, 1'b0, 0};
      vecs[15] = '{ 9,  0, 20, 1'b1, 1'b0, 1'b0, 0};
      vecs[16] = '{ 8,  0, 30, 1'b0, 1'b0, 1'b0, 0};

      // Reset state, checked while rst is still held.
      #2;
      check_all("reset", 1'b0, 1'b0, 1'b0, 0);

      for (int i = 0; i < 17; i++) begin
         do_reset();
         while (cyc < vecs[i].chk) step(cyc + 1 == vecs[i].ta, cyc + 1 == vecs[i].tb);
         check_all($sformatf("v%0d", i), vecs[i].q, vecs[i].ep, vecs[i].er, vecs[i].cnt);
      end

      // A+B at 40, rejected A at 47, accepted B at 48.
      do_reset();
      run_to(39);
      step(1'b1, 1'b1);
      run_to(46);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      check_all("ab40.c48", 1'b0, 1'b1, 1'b1, 2);
      run_to(51);
      check("ab40.q51", 32'(bus.q), 32'd1);
      run_to(58);
      check("ab40.q58", 32'(bus.q), 32'd1);
      step(1'b0, 1'b0);
      check("ab40.q59", 32'(bus.q), 32'd0);
      run_to(62);
      check_all("ab40.c62", 1'b0, 1'b0, 1'b1, 2);

      // Asynchronous reset with one pulse already delivered and another in flight.
      do_reset();
      run_to(9);
      step(1'b1, 1'b0);
      run_to(19);
      step(1'b1, 1'b0);
      run_to(24);
      check_all("mid.pre", 1'b1, 1'b0, 1'b0, 0);
      rst = 1'b1;
      #1;
      check("mid.q_async", 32'(bus.q), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      a   = 1'b0;
      b   = 1'b0;
      cyc = 0;
      run_to(2);
      step(1'b1, 1'b0);
      run_to(12);
      check_all("mid.c12", 1'b0, 1'b0, 1'b0, 0);
      run_to(30);
      check_all("mid.c30", 1'b0, 1'b0, 1'b0, 0);
      run_to(34);
      step(1'b1, 1'b0);
      run_to(46);
      check("mid.q46", 32'(bus.q), 32'd1);

      // Five violations: 8-bit counter reaches 5, 2-bit counter sticks at 3.
      do_reset();
      run_to(19);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      check("sat.cnt8", 32'(bus.err_count), 32'd5);
      check("sat.cnt2", 32'(bus2.err_count), 32'd3);
      check("sat.err2", 32'(bus2.err), 32'd1);
      check("sat.ep2", 32'(bus2.err_pulse), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
